pacman_sprite_engine: RTL and testbench

- Sits between the background path (draw_control address generation, frameRAM read) and color_mapper.
- Holds Pac-Man's screen position and facing direction, and steps them once per video frame from the USB keycode.
- For every DrawX/DrawY it overlays a 16x16, 4-frame animated, direction-rotated sprite on the frameRAM background index.
- Emits the final 4-bit color_index to color_mapper.

---
 rtl/pacman_pkg.sv | 62 ++++++
 rtl/pacman_sprite_rom.sv | 16 +
 rtl/pacman_sprite_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_pacman_sprite_engine.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared types, constants and helpers for the Pac-Man sprite engine.
package pacman_pkg;

  localparam int SPR_SIZE = 16;
  localparam int SPR_BITS = $clog2(SPR_SIZE);
  localparam int ROM_AW   = 2 + 2 * SPR_BITS;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    UP    = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    LATCH      = 2'd1,
    MOVE       = 2'd2,
    ANIMATE    = 2'd3
  } state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  localparam logic [3:0] TRANSPARENT_IDX = 4'h0;

  // Clamp a signed 11-bit coordinate into [0, hi]; never wraps.
  function automatic logic [9:0] clamp_axis(input logic signed [10:0] v,
                                            input logic [9:0] hi);
    logic [9:0] res;
    if (v < 11'sd0) begin
      res = 10'd0;
    end else if (v > $signed({1'b0, hi})) begin
      res = hi;
    end else begin
      res = v[9:0];
    end
    return res;
  endfunction

  // Sprite artwork: address is {frame, row, col}. The two leftmost columns
  // are transparent; the rest is a frame-dependent colour pattern in which
  // some texels also land on the transparent index.
  function automatic logic [3:0] sprite_pixel(input logic [ROM_AW-1:0] addr);
    logic [1:0]          f;
    logic [SPR_BITS-1:0] r;
    logic [SPR_BITS-1:0] c;
    logic [3:0]          v;
    f = addr[ROM_AW-1 -: 2];
    r = addr[2*SPR_BITS-1 -: SPR_BITS];
    c = addr[SPR_BITS-1:0];
    if (c < SPR_BITS'(2)) begin
      v = TRANSPARENT_IDX;
    end else begin
      v = 4'(r ^ c) + {1'b0, f, 1'b0} + {2'b00, f} + 4'd7;
    end
    return v;
  endfunction

endpackage

// File: rtl/pacman_sprite_rom.sv
// 1024x4 sprite texel store (4 animation frames of 16x16), combinational read.
// Contents come from the package artwork function so simulation and
// synthesis see the identical table.
module pacman_sprite_rom
  import pacman_pkg::*;
(
  input  logic [ROM_AW-1:0] addr,
  output logic [3:0]        data
);

  // Constant-table lookup; synthesises to a ROM / LUT tree.
  always_comb begin
    data = sprite_pixel(addr);
  end

endmodule

// File: rtl/pacman_sprite_engine.sv
// Pac-Man position/direction state machine stepped once per video frame,
// plus a 2-stage pixel pipeline overlaying the rotated, animated sprite on
// the frameRAM background index.
module pacman_sprite_engine
  import pacman_pkg::*;
#(
  parameter logic [9:0] START_X  = 10'd312,
  parameter logic [9:0] START_Y  = 10'd232,
  parameter logic [9:0] X_MAX    = 10'd624,
  parameter logic [9:0] Y_MAX    = 10'd464,
  parameter int         STEP     = 2,
  parameter int         ANIM_DIV = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       VGA_VS,
  input  logic [7:0] keycode,
  input  logic [3:0] bg_index,
  output logic [3:0] color_index_out,
  output logic [9:0] sprite_x,
  output logic [9:0] sprite_y,
  output logic [1:0] dir,
  output logic       frame_tick
);

  localparam int                 CNT_W    = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ANIM_DIV - 1);
  localparam logic signed [10:0] STEP_S   = 11'(STEP);

  // Frame sync
  logic vs_meta_r;
  logic vs_sync_r;
  logic vs_prev_r;
  logic vs_fall_s;
  logic frame_tick_r;

  // Movement state
  state_t           state_r,      state_nxt_s;
  dir_t             dir_r,        dir_nxt_s;
  logic [9:0]       x_r,          x_nxt_s;
  logic [9:0]       y_r,          y_nxt_s;
  logic             moved_r,      moved_nxt_s;
  logic [1:0]       anim_frame_r, anim_frame_nxt_s;
  logic [CNT_W-1:0] anim_cnt_r,   anim_cnt_nxt_s;
  logic signed [10:0] x_sum_s;
  logic signed [10:0] y_sum_s;

  // Pixel pipeline
  logic [9:0]          dx_s;
  logic [9:0]          dy_s;
  logic                hit_s;
  logic [SPR_BITS-1:0] rot_r_s;
  logic [SPR_BITS-1:0] rot_c_s;
  logic                hit_r;
  logic [ROM_AW-1:0]   rom_addr_r;
  logic [3:0]          rom_data_s;
  logic [3:0]          pix_sel_s;
  logic [3:0]          color_r;

  assign vs_fall_s = vs_prev_r & ~vs_sync_r;

  // Synchronise VGA_VS into CLK and register a one-cycle pulse on its fall.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_meta_r    <= 1'b0;
      vs_sync_r    <= 1'b0;
      vs_prev_r    <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      vs_meta_r    <= VGA_VS;
      vs_sync_r    <= vs_meta_r;
      vs_prev_r    <= vs_sync_r;
      frame_tick_r <= vs_fall_s;
    end
  end

  // Movement FSM state and the position/direction/animation it owns.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r      <= WAIT_FRAME;
      dir_r        <= RIGHT;
      x_r          <= START_X;
      y_r          <= START_Y;
      moved_r      <= 1'b0;
      anim_frame_r <= 2'd0;
      anim_cnt_r   <= '0;
    end else begin
      state_r      <= state_nxt_s;
      dir_r        <= dir_nxt_s;
      x_r          <= x_nxt_s;
      y_r          <= y_nxt_s;
      moved_r      <= moved_nxt_s;
      anim_frame_r <= anim_frame_nxt_s;
      anim_cnt_r   <= anim_cnt_nxt_s;
    end
  end

  // Next-state logic: latch key, take one clamped step, advance animation.
  always_comb begin
    state_nxt_s      = state_r;
    dir_nxt_s        = dir_r;
    x_nxt_s          = x_r;
    y_nxt_s          = y_r;
    moved_nxt_s      = moved_r;
    anim_frame_nxt_s = anim_frame_r;
    anim_cnt_nxt_s   = anim_cnt_r;
    x_sum_s          = $signed({1'b0, x_r});
    y_sum_s          = $signed({1'b0, y_r});

    case (dir_r)
      RIGHT:   x_sum_s = $signed({1'b0, x_r}) + STEP_S;
      LEFT:    x_sum_s = $signed({1'b0, x_r}) - STEP_S;
      DOWN:    y_sum_s = $signed({1'b0, y_r}) + STEP_S;
      UP:      y_sum_s = $signed({1'b0, y_r}) - STEP_S;
      default: x_sum_s = $signed({1'b0, x_r});
    endcase

    case (state_r)
      WAIT_FRAME: begin
        if (frame_tick_r) begin
          state_nxt_s = LATCH;
        end else begin
          state_nxt_s = WAIT_FRAME;
        end
      end
      LATCH: begin
        case (keycode)
          KEY_W:   dir_nxt_s = UP;
          KEY_S:   dir_nxt_s = DOWN;
          KEY_A:   dir_nxt_s = LEFT;
          KEY_D:   dir_nxt_s = RIGHT;
          default: dir_nxt_s = dir_r;
        endcase
        state_nxt_s = MOVE;
      end
      MOVE: begin
        x_nxt_s     = clamp_axis(x_sum_s, X_MAX);
        y_nxt_s     = clamp_axis(y_sum_s, Y_MAX);
        moved_nxt_s = (x_nxt_s != x_r) || (y_nxt_s != y_r);
        state_nxt_s = ANIMATE;
      end
      ANIMATE: begin
        // A sprite pinned against a wall keeps its current mouth pose.
        if (moved_r) begin
          if (anim_cnt_r == CNT_LAST) begin
            anim_cnt_nxt_s   = '0;
            anim_frame_nxt_s = anim_frame_r + 2'd1;
          end else begin
            anim_cnt_nxt_s   = anim_cnt_r + CNT_W'(1);
            anim_frame_nxt_s = anim_frame_r;
          end
        end else begin
          anim_cnt_nxt_s   = anim_cnt_r;
          anim_frame_nxt_s = anim_frame_r;
        end
        state_nxt_s = WAIT_FRAME;
      end
      default: begin
        state_nxt_s = WAIT_FRAME;
      end
    endcase
  end

  // Stage 1 combinational: sprite-relative offset, hit test and rotation.
  always_comb begin
    dx_s  = DrawX - x_r;
    dy_s  = DrawY - y_r;
    // Pixels left of / above the sprite wrap to large values and miss.
    hit_s = (dx_s < 10'(SPR_SIZE)) && (dy_s < 10'(SPR_SIZE));
    case (dir_r)
      RIGHT: begin
        rot_r_s = dy_s[SPR_BITS-1:0];
        rot_c_s = dx_s[SPR_BITS-1:0];
      end
      LEFT: begin
        rot_r_s = dy_s[SPR_BITS-1:0];
        rot_c_s = ~dx_s[SPR_BITS-1:0];
      end
      DOWN: begin
        rot_r_s = dx_s[SPR_BITS-1:0];
        rot_c_s = dy_s[SPR_BITS-1:0];
      end
      UP: begin
        rot_r_s = ~dx_s[SPR_BITS-1:0];
        rot_c_s = dy_s[SPR_BITS-1:0];
      end
      default: begin
        rot_r_s = dy_s[SPR_BITS-1:0];
        rot_c_s = dx_s[SPR_BITS-1:0];
      end
    endcase
  end

  // Stage 1 register: hit flag and texel address.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hit_r      <= 1'b0;
      rom_addr_r <= '0;
    end else begin
      hit_r      <= hit_s;
      rom_addr_r <= {anim_frame_r, rot_r_s, rot_c_s};
    end
  end

  pacman_sprite_rom u_rom (
    .addr (rom_addr_r),
    .data (rom_data_s)
  );

  // Stage 2 combinational: opaque sprite texel wins, otherwise background.
  always_comb begin
    if (hit_r && (rom_data_s != TRANSPARENT_IDX)) begin
      pix_sel_s = rom_data_s;
    end else begin
      pix_sel_s = bg_index;
    end
  end

  // Stage 2 register: final colour index towards color_mapper.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      color_r <= 4'h0;
    end else begin
      color_r <= pix_sel_s;
    end
  end

  assign color_index_out = color_r;
  assign sprite_x        = x_r;
  assign sprite_y        = y_r;
  assign dir             = dir_r;
  assign frame_tick      = frame_tick_r;

endmodule

// File: tb/tb_pacman_sprite_engine.sv
// Self-checking bench for pacman_sprite_engine: directed steps plus random
// keys/pixels against a frame-level behavioural model.
module tb_pacman_sprite_engine;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       VGA_VS;
  logic [7:0] keycode;
  logic [3:0] bg_index;
  logic [3:0] color_index_out;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic [1:0] dir;
  logic       frame_tick;

  int n_total = 0;
  int n_pass  = 0;

  // Model state: position, facing, animation frame and divider count.
  int m_x, m_y, m_dir, m_anim, m_cnt;
  int qx[$];
  int qy[$];
  int qbg[$];

  always #10 CLK = ~CLK;

  pacman_sprite_engine dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .DrawX           (DrawX),
    .DrawY           (DrawY),
    .VGA_VS          (VGA_VS),
    .keycode         (keycode),
    .bg_index        (bg_index),
    .color_index_out (color_index_out),
    .sprite_x        (sprite_x),
    .sprite_y        (sprite_y),
    .dir             (dir),
    .frame_tick      (frame_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Artwork as seen by the bench: left two columns clear, colour pattern elsewhere.
  function automatic int ref_pixel(int f, int r, int c);
    if (c < 2) return 0;
    return ((r ^ c) + 3 * f + 7) % 16;
  endfunction

  function automatic int exp_color(int px, int py, int bg);
    int dx, dy, r, c, p;
    dx = px - m_x;
    dy = py - m_y;
    if (dx < 0 || dx > 15 || dy < 0 || dy > 15) return bg;
    case (m_dir)
      0:       begin r = dy;      c = dx;      end
      1:       begin r = dx;      c = dy;      end
      2:       begin r = dy;      c = 15 - dx; end
      default: begin r = 15 - dx; c = dy;      end
    endcase
    p = ref_pixel(m_anim, r, c);
    return (p != 0) ? p : bg;
  endfunction

  task automatic model_reset();
    m_x = 312; m_y = 232; m_dir = 0; m_anim = 0; m_cnt = 0;
  endtask

  task automatic model_frame(input logic [7:0] key);
    int nx, ny;
    case (key)
      8'h1A:   m_dir = 3;
      8'h16:   m_dir = 1;
      8'h04:   m_dir = 2;
      8'h07:   m_dir = 0;
      default: m_dir = m_dir;
    endcase
    nx = m_x; ny = m_y;
    case (m_dir)
      0:       nx = nx + 2;
      1:       ny = ny + 2;
      2:       nx = nx - 2;
      default: ny = ny - 2;
    endcase
    if (nx < 0) nx = 0;
    if (nx > 624) nx = 624;
    if (ny < 0) ny = 0;
    if (ny > 464) ny = 464;
    if (nx != m_x || ny != m_y) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == 4) begin
        m_cnt  = 0;
        m_anim = (m_anim + 1) % 4;
      end
    end
    m_x = nx; m_y = ny;
  endtask

  // One vertical-sync fall with a key held; checks tick timing and new position.
  task automatic do_frame(input logic [7:0] key);
    @(negedge CLK);
    keycode = key;
    VGA_VS  = 1'b0;
    @(negedge CLK); check("tick_early1", {31'd0, frame_tick}, 32'd0);
    @(negedge CLK); check("tick_early2", {31'd0, frame_tick}, 32'd0);
    @(negedge CLK); check("tick_pulse",  {31'd0, frame_tick}, 32'd1);
    @(negedge CLK); check("tick_width",  {31'd0, frame_tick}, 32'd0);
    repeat (4) @(negedge CLK);
    VGA_VS = 1'b1;
    repeat (6) @(negedge CLK);
    model_frame(key);
    check("sprite_x", {22'd0, sprite_x}, m_x);
    check("sprite_y", {22'd0, sprite_y}, m_y);
    check("dir",      {30'd0, dir},      m_dir);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    model_reset();
    repeat (3) @(negedge CLK);
  endtask

  // Stream queued pixels one per clock; each result is due 2 clocks later.
  task automatic run_scan();
    int n;
    n = qx.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge CLK);
      if (i < n) begin
        DrawX = 10'(qx[i]);
        DrawY = 10'(qy[i]);
      end
      if (i >= 1 && i <= n) bg_index = 4'(qbg[i-1]);
      if (i >= 2) check("pixel", {28'd0, color_index_out}, exp_color(qx[i-2], qy[i-2], qbg[i-2]));
    end
    qx.delete(); qy.delete(); qbg.delete();
  endtask

  task automatic queue_random(input int n);
    for (int i = 0; i < n; i++) begin
      qx.push_back((m_x + int'($urandom_range(0, 23)) - 4) & 1023);
      qy.push_back((m_y + int'($urandom_range(0, 23)) - 4) & 1023);
      qbg.push_back(int'($urandom_range(0, 15)));
    end
  endtask

  task automatic queue_full_sprite(input int bg);
    for (int r = 0; r < 18; r++) begin
      for (int c = 0; c < 18; c++) begin
        qx.push_back((m_x - 1 + c) & 1023);
        qy.push_back((m_y - 1 + r) & 1023);
        qbg.push_back(bg);
      end
    end
  endtask

  task automatic probe(input int px, input int py, input int bg, output logic [3:0] col);
    @(negedge CLK);
    DrawX = 10'(px);
    DrawY = 10'(py);
    @(negedge CLK);
    bg_index = 4'(bg);
    @(negedge CLK);
    col = color_index_out;
  endtask

  initial begin
    logic [3:0] col;
    logic [7:0] key;
    int         sel;

    RESET_N  = 1'b0;
    VGA_VS   = 1'b1;
    keycode  = 8'h00;
    DrawX    = 10'd0;
    DrawY    = 10'd0;
    bg_index = 4'd0;
    model_reset();

    // Reset values
    repeat (3) @(negedge CLK);
    check("rst_x",     {22'd0, sprite_x},        32'd312);
    check("rst_y",     {22'd0, sprite_y},        32'd232);
    check("rst_dir",   {30'd0, dir},             32'd0);
    check("rst_color", {28'd0, color_index_out}, 32'd0);
    check("rst_tick",  {31'd0, frame_tick},      32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK);

    // No keys, three frames: keeps moving right
    repeat (3) do_frame(8'h00);
    check("idle3_x", {22'd0, sprite_x}, 32'd318);
    check("idle3_y", {22'd0, sprite_y}, 32'd232);

    // W held two frames, then released
    do_reset();
    do_frame(8'h1A);
    do_frame(8'h1A);
    check("w2_dir", {30'd0, dir},      32'd3);
    check("w2_y",   {22'd0, sprite_y}, 32'd228);
    do_frame(8'h00);
    check("w0_y",   {22'd0, sprite_y}, 32'd226);

    // Scan row 0 of the sprite at the start position, bg=5
    do_reset();
    for (int x = 311; x <= 328; x++) begin
      qx.push_back(x); qy.push_back(232); qbg.push_back(5);
    end
    run_scan();
    probe(312, 232, 5, col); check("row0_c0",  {28'd0, col}, 32'd5);
    probe(314, 232, 5, col); check("row0_c2",  {28'd0, col}, 32'd9);
    probe(311, 232, 5, col); check("row0_l",   {28'd0, col}, 32'd5);
    probe(328, 232, 5, col); check("row0_r",   {28'd0, col}, 32'd5);
    queue_random(40);
    run_scan();

    // Face left: origin pixel reads column 15
    do_frame(8'h04);
    probe(310, 232, 5, col); check("left_c15", {28'd0, col}, 32'd6);
    repeat (7) do_frame(8'h04);
    queue_full_sprite(3);
    run_scan();

    // Right wall: clamp at 624 and hold the animation frame
    for (int k = 0; k < 400 && m_x != 624; k++) do_frame(8'h07);
    repeat (5) do_frame(8'h07);
    check("wall_x", {22'd0, sprite_x}, 32'd624);
    queue_full_sprite(11);
    run_scan();

    // Top wall: clamp at 0, pixels above wrap and miss
    for (int k = 0; k < 300 && m_y != 0; k++) do_frame(8'h1A);
    repeat (3) do_frame(8'h1A);
    check("wall_y", {22'd0, sprite_y}, 32'd0);
    queue_full_sprite(7);
    run_scan();

    // Random keys and random pixels near the sprite
    for (int f = 0; f < 60; f++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       key = 8'h00;
        1:       key = 8'h1A;
        2:       key = 8'h16;
        3:       key = 8'h04;
        4:       key = 8'h07;
        default: key = 8'($urandom_range(0, 255));
      endcase
      do_frame(key);
      if (f % 10 == 9) begin
        queue_random(30);
        run_scan();
      end
    end

    // Reset while the FSM sits in MOVE: no step may survive it
    @(negedge CLK);
    keycode = 8'h07;
    VGA_VS  = 1'b0;
    repeat (5) @(negedge CLK);
    RESET_N = 1'b0;
    #1;
    check("mv_rst_x",     {22'd0, sprite_x},        32'd312);
    check("mv_rst_y",     {22'd0, sprite_y},        32'd232);
    check("mv_rst_dir",   {30'd0, dir},             32'd0);
    check("mv_rst_color", {28'd0, color_index_out}, 32'd0);
    VGA_VS = 1'b1;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    model_reset();
    repeat (12) @(negedge CLK);
    check("post_rst_x",    {22'd0, sprite_x},   32'd312);
    check("post_rst_y",    {22'd0, sprite_y},   32'd232);
    check("post_rst_tick", {31'd0, frame_tick}, 32'd0);
    do_frame(8'h00);
    check("post_rst_step", {22'd0, sprite_x}, 32'd314);

    // Reset in the middle of a scan clears the colour output at once
    probe(316, 232, 5, col);
    check("scan_pre", {28'd0, col}, exp_color(316, 232, 5));
    RESET_N = 1'b0;
    #1;
    check("scan_rst_color", {28'd0, color_index_out}, 32'd0);
    check("scan_rst_x",     {22'd0, sprite_x},        32'd312);
    @(negedge CLK);
    RESET_N = 1'b1;
    model_reset();
    repeat (2) @(negedge CLK);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
